imem_fetch: RTL
===============

// Module: imem_fetch
// PURPOSE
//  Parametrised, synchronous instruction memory with request/response handshake; successor to the fixed combinational ROM.
//  Sits between the PC/fetch stage and decode; RAM array is writable through a program port (loader/testbench).
//  Registered read: 1-cycle latency; 2-entry response skid buffer absorbs decode back-pressure; flush support.
// PARAMETERS
//  DATA_W    32        instruction width (bits)
//  DEPTH     16        number of instruction words; AW = $clog2(DEPTH)
//  BYTE_ADDR 1         1: word index = req_pc[AW+1:2], misaligned if req_pc[1:0]!=0; 0: index = req_pc[AW-1:0]
//  NOP_INS   32'h0     instruction returned on any error
//  INIT_FILE ""        if non-empty, $readmemh at elaboration; otherwise array contents undefined
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       fetch request valid
//  req_ready   out  1       block can accept request this cycle
//  req_pc      in   32      fetch address
//  flush       in   1       discard in-flight and buffered responses
//  rsp_valid   out  1       response valid
//  rsp_ready   in   1       consumer accepts response
//  rsp_ins     out  DATA_W  fetched instruction
//  rsp_pc      out  32      PC of this response
//  rsp_err     out  1       out-of-range (index >= DEPTH or PC bits above index nonzero) or misaligned
//  prog_we     in   1       program write enable
//  prog_addr   in   AW      program word index
//  prog_data   in   DATA_W  program data
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_ins=NOP_INS, rsp_pc=0, rsp_err=0, in-flight flag=0, FIFO empty; array not reset.
//  - Accept: request taken when req_valid&&req_ready. Array read registered; entry enters FIFO next cycle.
//  - Latency: accepted at cycle N -> rsp_valid at N+1 if FIFO was empty (fall-through from read stage).
//  - req_ready = (fifo_count + inflight) < 2 ; no combinational path from rsp_ready to req_ready.
//  - Throughput: 1 response/cycle while rsp_ready=1. Response order = request order.
//  - rsp_* held stable while rsp_valid&&!rsp_ready.
//  - Error: rsp_err=1, rsp_ins=NOP_INS, array not read; entry still occupies a slot and is consumed normally.
//  - Program write: write at clk edge; same-cycle read of same index returns OLD data (read-before-write).
//  - prog_we with prog_addr >= DEPTH ignored.
//  - Flush: at the edge where flush=1, FIFO cleared, in-flight dropped, any request accepted that same cycle dropped;
//    req_ready=0 while flush=1; rsp_valid=0 the following cycle.
//  - Simultaneous pop and push with FIFO full: allowed, count unchanged.
//  - Async reset mid-transfer: all state to reset values immediately; no response emitted for pre-reset requests.
// CONFIGURATION
//  IMEM_PERF_EN defined: extra outputs perf_fetch_cnt[31:0] (increments per accepted response,
//    rsp_valid&&rsp_ready) and perf_stall_cnt[31:0] (increments per cycle req_valid&&!req_ready);
//    both wrap at 2^32, reset to 0, unaffected by flush.
//  IMEM_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  imem_pkg: NOP_INS default constant, typedef imem_rsp_t {ins, pc, err}, error-check function.
//  Sub-module imem_rsp_fifo: 2-entry FIFO of imem_rsp_t with flush, count, fall-through output.
//  Top: array, address decode/error check, read register + in-flight flag, perf counters.
// TESTING
//  1 DEPTH=16,BYTE_ADDR=1: program idx3=32'h00221020; req_pc=0x0C, rsp_ready=1 -> next cycle rsp_ins=32'h00221020, rsp_pc=0x0C, err=0.
//  2 Back-to-back reqs 0x00,0x04,0x08, rsp_ready=1 -> 3 consecutive rsp cycles, in order, req_ready stays 1.
//  3 rsp_ready=0 with req_valid=1 held -> req_ready=0 after 2 accepts; rsp held stable; release -> drains in order, no loss/dup.
//  4 req_pc=0x40 (out of range) and 0x06 (misaligned) -> rsp_err=1, rsp_ins=32'h0.
//  5 prog_we idx5=32'hAAAA0000 same cycle as read of 0x14 (old 32'h12345678) -> rsp 32'h12345678; next read 32'hAAAA0000.
//  6 Two buffered + one in flight, assert flush -> next cycle rsp_valid=0; rst_n low mid-stream -> outputs at reset values async.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch block:
// the default NOP word, the response record and the fetch-address error check.
package imem_pkg;

  localparam int          IMEM_DATA_W  = 32;
  localparam logic [31:0] IMEM_NOP_INS = 32'h0;

  // Response record carried from the read stage through the skid buffer.
  typedef struct packed {
    logic [IMEM_DATA_W-1:0] ins;
    logic [31:0]            pc;
    logic                   err;
  } imem_rsp_t;

  // A fetch address is bad when misaligned (byte addressing only), when any
  // PC bit above the word index is set, or when the index is past the array.
  function automatic logic imem_addr_err(input logic [31:0] pc,
                                         input logic [31:0] aw,
                                         input logic [31:0] depth,
                                         input logic        byte_addr);
    logic [31:0] word;
    logic [31:0] idx_mask;
    logic        misalign;
    logic        upper;
    logic        oor;
    word     = byte_addr ? (pc >> 2) : pc;
    idx_mask = (32'd1 << aw) - 32'd1;
    misalign = byte_addr && (pc[1:0] != 2'b00);
    upper    = (word >> aw) != 32'd0;
    oor      = (word & idx_mask) >= depth;
    return misalign | upper | oor;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response skid buffer with fall-through: when empty, a pushed entry
// is presented on the output in the same cycle. Flush empties it at the edge.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter type rsp_t = imem_rsp_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  rsp_t       i_push_data,
  input  logic       i_pop,
  output logic       o_valid,
  output rsp_t       o_data,
  output logic [1:0] o_count
);

  rsp_t       r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_empty;
  logic w_pop;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  assign w_empty  = (r_count == 2'd0);
  assign o_valid  = !w_empty || i_push;
  assign o_data   = w_empty ? i_push_data : r_mem[r_rd_ptr];
  assign w_pop    = o_valid && i_pop;
  // An entry pushed into an empty buffer and consumed at once is never stored.
  assign w_bypass = w_empty && i_push && i_pop;
  // A full buffer may still take a push when its head leaves in the same cycle.
  assign w_wr     = i_push && !w_bypass && ((r_count != 2'd2) || w_pop);
  assign w_rd     = w_pop && !w_empty;
  assign o_count  = r_count;

  // Pointer and occupancy bookkeeping; flush discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) r_wr_ptr <= !r_wr_ptr;
      if (w_rd) r_rd_ptr <= !r_rd_ptr;
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

  // Entry storage; payload needs no reset since occupancy qualifies it.
  always_ff @(posedge clk) begin
    if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/imem_fetch.sv
// Synchronous instruction memory with request/response handshake, registered
// read (1-cycle latency), 2-entry response skid buffer and flush.
// Optional build macro IMEM_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter int                BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_INS   = DATA_W'(IMEM_NOP_INS),
  parameter string             INIT_FILE = "",
  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_ins,
  output logic [31:0]       rsp_pc,
  output logic              rsp_err,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [DATA_W-1:0] prog_data
`ifdef IMEM_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] ins;
    logic [31:0]       pc;
    logic              err;
  } rsp_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_inf_vld;
  rsp_t              r_inf;

  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_acc;
  logic          w_prog_ok;
  logic [1:0]    w_count;
  logic [1:0]    w_occ;
  rsp_t          w_head;

  if (BYTE_ADDR != 0) begin : g_byte_idx
    assign w_idx = req_pc[AW+1:2];
  end else begin : g_word_idx
    assign w_idx = req_pc[AW-1:0];
  end

  // Power-of-two arrays cover every program index; others must bound it.
  if (DEPTH == (1 << AW)) begin : g_prog_full
    assign w_prog_ok = 1'b1;
  end else begin : g_prog_bound
    assign w_prog_ok = ({{(32-AW){1'b0}}, prog_addr} < 32'(DEPTH));
  end

  assign w_err = imem_addr_err(req_pc, 32'(AW), 32'(DEPTH), BYTE_ADDR != 0);
  // Occupancy counts buffered entries plus the one in the read stage, so the
  // accept decision never depends on rsp_ready in the same cycle.
  assign w_occ     = w_count + {1'b0, r_inf_vld};
  assign req_ready = !flush && (w_occ < 2'd2);
  assign w_acc     = req_valid && req_ready;

  // Loader write port; a read of the same index this cycle sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we && w_prog_ok) r_mem[prog_addr] <= prog_data;
  end

  // Read stage: registered array read, error entries skip the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inf_vld <= 1'b0;
      r_inf     <= '{ins: NOP_INS, pc: 32'h0, err: 1'b0};
    end else begin
      r_inf_vld <= w_acc;
      if (w_acc) r_inf <= '{ins: (w_err ? NOP_INS : r_mem[w_idx]), pc: req_pc, err: w_err};
    end
  end

  imem_rsp_fifo #(
    .rsp_t(rsp_t)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_push     (r_inf_vld),
    .i_push_data(r_inf),
    .i_pop      (rsp_ready),
    .o_valid    (rsp_valid),
    .o_data     (w_head),
    .o_count    (w_count)
  );

  assign rsp_ins = w_head.ins;
  assign rsp_pc  = w_head.pc;
  assign rsp_err = w_head.err;

`ifdef IMEM_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Free-running event counters; flush does not touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= 32'h0;
      r_perf_stall <= 32'h0;
    end else begin
      if (rsp_valid && rsp_ready) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (req_valid && !req_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
